// File: rtl/levenshtein_pkg.sv
// Shared types and constants for the Levenshtein dictionary search engine.
package levenshtein_pkg;
  typedef enum logic [1:0] {
    READ_DICT = 2'd0,
    READ_VEC  = 2'd1,
    STEP      = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [2:0] ADDR_CTRL      = 3'd0;
  localparam logic [2:0] ADDR_LENGTH    = 3'd1;
  localparam logic [2:0] ADDR_DISTANCE  = 3'd2;
  localparam logic [2:0] ADDR_THRESHOLD = 3'd3;
  localparam logic [2:0] ADDR_IDX_HI    = 3'd4;
  localparam logic [2:0] ADDR_IDX_LO    = 3'd5;
  localparam logic [2:0] ADDR_CNT_HI    = 3'd6;
  localparam logic [2:0] ADDR_CNT_LO    = 3'd7;

  localparam logic [7:0] END_OF_WORD = 8'hFE;
  localparam logic [7:0] END_OF_DICT = 8'hFF;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_DONE_BIT   = 1;
  localparam int CTRL_ERROR_BIT  = 2;
endpackage

// File: rtl/levenshtein_step.sv
// One column of the bit-parallel edit-distance recurrence (global alignment variant).
module levenshtein_step #(
  parameter int BITVECTOR_WIDTH = 16
) (
  input  logic [BITVECTOR_WIDTH-1:0] i_pm,
  input  logic [BITVECTOR_WIDTH-1:0] i_vp,
  input  logic [BITVECTOR_WIDTH-1:0] i_vn,
  input  logic [BITVECTOR_WIDTH-1:0] i_mask,
  output logic [BITVECTOR_WIDTH-1:0] o_vp_next,
  output logic [BITVECTOR_WIDTH-1:0] o_vn_next,
  output logic                       o_inc,
  output logic                       o_dec
);
  logic [BITVECTOR_WIDTH-1:0] w_x, w_d0, w_hp, w_hn, w_xh;

  assign w_x  = i_pm | i_vn;
  assign w_d0 = (((i_vp & w_x) + i_vp) ^ i_vp) | w_x;
  assign w_hn = i_vp & w_d0;
  assign w_hp = i_vn | ~(i_vp | w_d0);
  // The top row grows by one per text character, hence the forced carry-in.
  assign w_xh = (w_hp << 1) | BITVECTOR_WIDTH'(1);

  assign o_vn_next = w_xh & w_d0;
  assign o_vp_next = (w_hn << 1) | ~(w_xh | w_d0);
  assign o_inc     = |(w_hp & i_mask);
  assign o_dec     = |(w_hn & i_mask);
endmodule

// File: rtl/levenshtein_engine.sv
// Streams a dictionary over Wishbone and tracks the closest word to the query.
// Optional LEVENSHTEIN_THRESHOLD_EN adds the THRESHOLD register and a match counter.
module levenshtein_engine
  import levenshtein_pkg::*;
#(
  parameter int MASTER_ADDR_WIDTH = 24,
  parameter int SLAVE_ADDR_WIDTH  = 24,
  parameter int BITVECTOR_WIDTH   = 16,
  parameter int DISTANCE_WIDTH    = 8,
  parameter int ID_WIDTH          = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  output logic                         wbm_cyc_o,
  output logic                         wbm_stb_o,
  output logic [MASTER_ADDR_WIDTH-1:0] wbm_adr_o,
  output logic                         wbm_we_o,
  output logic [7:0]                   wbm_dat_o,
  input  logic                         wbm_ack_i,
  input  logic                         wbm_err_i,
  input  logic                         wbm_rty_i,
  input  logic [7:0]                   wbm_dat_i,
  input  logic                         wbs_cyc_i,
  input  logic                         wbs_stb_i,
  input  logic                         wbs_we_i,
  input  logic [SLAVE_ADDR_WIDTH-1:0]  wbs_adr_i,
  input  logic [7:0]                   wbs_dat_i,
  output logic                         wbs_ack_o,
  output logic                         wbs_err_o,
  output logic                         wbs_rty_o,
  output logic [7:0]                   wbs_dat_o
);
  localparam int BVW    = BITVECTOR_WIDTH;
  localparam int BYTES  = BVW / 8;
  localparam int BEAT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  state_t                       r_state, w_state_next;
  logic                         r_cyc, r_enable, r_done, r_error, r_wbs_ack;
  logic [7:0]                   r_length, r_char;
  logic [BEAT_W-1:0]            r_beat;
  logic [MASTER_ADDR_WIDTH-2:0] r_dict_address;
  logic [BVW-1:0]               r_pm, r_vp, r_vn;
  logic [DISTANCE_WIDTH-1:0]    r_d, r_best_distance;
  logic [ID_WIDTH-1:0]          r_idx, r_best_idx;

  logic                         w_slave_req, w_slave_wr, w_ctrl_wr, w_len_bad;
  logic                         w_m_ack, w_m_fail, w_last_beat, w_inc, w_dec;
  logic [BVW-1:0]               w_vp_init, w_mask, w_pm_shift, w_vp_next, w_vn_next;
  logic [DISTANCE_WIDTH-1:0]    w_len_d;
  logic [15:0]                  w_idx16;
  logic [7:0]                   w_rd_data;
  logic                         w_unused;

`ifdef LEVENSHTEIN_THRESHOLD_EN
  logic [7:0]  r_threshold;
  logic [15:0] r_cnt;
  logic        w_cnt_hit;
  assign w_cnt_hit = (32'(r_d) <= 32'(r_threshold));
`endif

  assign w_slave_req = wbs_cyc_i & wbs_stb_i & ~r_wbs_ack;
  assign w_slave_wr  = w_slave_req & wbs_we_i;
  assign w_ctrl_wr   = w_slave_wr & (wbs_adr_i[2:0] == ADDR_CTRL);
  assign w_len_bad   = (r_length == 8'd0) || (32'(r_length) > BVW);
  assign w_m_ack     = r_cyc & wbm_ack_i;
  assign w_m_fail    = r_cyc & (wbm_err_i | wbm_rty_i);
  assign w_last_beat = (r_beat == BEAT_W'(BYTES - 1));
  assign w_len_d     = DISTANCE_WIDTH'(r_length);
  assign w_pm_shift  = (r_pm << 8) | BVW'(wbm_dat_i);
  assign w_idx16     = 16'(r_best_idx);
  assign w_unused    = ^wbs_adr_i[SLAVE_ADDR_WIDTH-1:3];

  for (genvar gi = 0; gi < BVW; gi++) begin : g_bits
    assign w_vp_init[gi] = (32'(r_length) > gi);
    assign w_mask[gi]    = (32'(r_length) == gi + 1);
  end

  levenshtein_step #(.BITVECTOR_WIDTH(BVW)) u_step (
    .i_pm(r_pm), .i_vp(r_vp), .i_vn(r_vn), .i_mask(w_mask),
    .o_vp_next(w_vp_next), .o_vn_next(w_vn_next), .o_inc(w_inc), .o_dec(w_dec)
  );

  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
  assign wbm_we_o  = 1'b0;
  assign wbm_dat_o = 8'h00;
  // Vector addresses have a zero MSB through zero-extension of {char, beat}.
  assign wbm_adr_o = (r_state == READ_DICT) ? {1'b1, r_dict_address}
                                            : MASTER_ADDR_WIDTH'({r_char, r_beat});
  assign wbs_ack_o = r_wbs_ack;
  assign wbs_err_o = 1'b0;
  assign wbs_rty_o = 1'b0;
  assign wbs_dat_o = w_rd_data;

  always_comb begin
    w_state_next = r_state;
    if (w_ctrl_wr) w_state_next = READ_DICT;
    else if (w_m_fail) w_state_next = DONE;
    else begin
      case (r_state)
        READ_DICT: if (w_m_ack) begin
          if (wbm_dat_i == END_OF_DICT) w_state_next = DONE;
          else if (wbm_dat_i != END_OF_WORD) w_state_next = READ_VEC;
        end
        READ_VEC:  if (w_m_ack && w_last_beat) w_state_next = STEP;
        STEP:      w_state_next = READ_DICT;
        default:   w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= READ_DICT;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cyc <= 1'b0; r_enable <= 1'b0; r_done <= 1'b0; r_error <= 1'b0; r_wbs_ack <= 1'b0;
      r_length <= '0; r_char <= '0; r_beat <= '0; r_dict_address <= '0;
      r_pm <= '0; r_vp <= '0; r_vn <= '0; r_d <= '0; r_best_distance <= '1;
      r_idx <= '0; r_best_idx <= '0;
`ifdef LEVENSHTEIN_THRESHOLD_EN
      r_threshold <= '0; r_cnt <= '0;
`endif
    end else begin
      r_wbs_ack <= w_slave_req;
      if (w_slave_wr && wbs_adr_i[2:0] == ADDR_LENGTH) r_length <= wbs_dat_i;
`ifdef LEVENSHTEIN_THRESHOLD_EN
      if (w_slave_wr && wbs_adr_i[2:0] == ADDR_THRESHOLD) r_threshold <= wbs_dat_i;
`endif
      // A CTRL write outranks any master termination arriving on the same edge.
      if (w_ctrl_wr) begin
        r_cyc <= 1'b0; r_done <= 1'b0; r_idx <= '0; r_best_idx <= '0;
        r_best_distance <= '1; r_d <= w_len_d; r_vp <= w_vp_init; r_vn <= '0;
        r_dict_address <= '0;
        r_enable <= wbs_dat_i[CTRL_ENABLE_BIT] & ~w_len_bad;
        r_error  <= wbs_dat_i[CTRL_ENABLE_BIT] & w_len_bad;
`ifdef LEVENSHTEIN_THRESHOLD_EN
        r_cnt <= '0;
`endif
      end else if (w_m_fail) begin
        r_cyc <= 1'b0; r_enable <= 1'b0; r_error <= 1'b1;
      end else if (w_m_ack) begin
        r_cyc <= 1'b0;
        case (r_state)
          READ_DICT: begin
            r_dict_address <= r_dict_address + (MASTER_ADDR_WIDTH-1)'(1);
            if (wbm_dat_i == END_OF_DICT) begin
              r_enable <= 1'b0; r_done <= 1'b1;
            end else if (wbm_dat_i == END_OF_WORD) begin
              if (r_d < r_best_distance) begin
                r_best_distance <= r_d; r_best_idx <= r_idx;
              end
`ifdef LEVENSHTEIN_THRESHOLD_EN
              if (w_cnt_hit && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
`endif
              r_idx <= r_idx + ID_WIDTH'(1);
              r_d <= w_len_d; r_vp <= w_vp_init; r_vn <= '0;
            end else begin
              r_char <= wbm_dat_i; r_beat <= '0;
            end
          end
          READ_VEC: begin
            r_pm <= w_pm_shift; r_beat <= r_beat + BEAT_W'(1);
          end
          default: ;
        endcase
      end else if (r_state == STEP) begin
        r_vp <= w_vp_next; r_vn <= w_vn_next;
        if (w_inc && r_d != '1) r_d <= r_d + DISTANCE_WIDTH'(1);
        else if (w_dec && r_d != '0) r_d <= r_d - DISTANCE_WIDTH'(1);
      end else if (r_enable && !r_cyc && (r_state == READ_DICT || r_state == READ_VEC)) begin
        r_cyc <= 1'b1;
      end
    end
  end

  always_comb begin
    w_rd_data = 8'h00;
    case (wbs_adr_i[2:0])
      ADDR_CTRL: begin
        w_rd_data[CTRL_ENABLE_BIT] = r_enable;
        w_rd_data[CTRL_DONE_BIT]   = r_done;
        w_rd_data[CTRL_ERROR_BIT]  = r_error;
      end
      ADDR_LENGTH:    w_rd_data = r_length;
      ADDR_DISTANCE:  w_rd_data = 8'(r_best_distance);
      ADDR_IDX_HI:    w_rd_data = w_idx16[15:8];
      ADDR_IDX_LO:    w_rd_data = w_idx16[7:0];
`ifdef LEVENSHTEIN_THRESHOLD_EN
      ADDR_THRESHOLD: w_rd_data = r_threshold;
      ADDR_CNT_HI:    w_rd_data = r_cnt[15:8];
      ADDR_CNT_LO:    w_rd_data = r_cnt[7:0];
`endif
      default:        w_rd_data = 8'h00;
    endcase
  end
endmodule

// File: tb/tb_levenshtein_engine.sv
// Directed bench for levenshtein_engine (32-bit vectors, zero-wait memory model).
module tb_levenshtein_engine;
  import levenshtein_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [23:0] wbm_adr_o;
  logic [7:0]  wbm_dat_o, wbm_dat_i;
  logic        wbm_ack_i, wbm_err_i, wbm_rty_i;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [23:0] wbs_adr_i;
  logic [7:0]  wbs_dat_i, wbs_dat_o;
  logic        wbs_ack_o, wbs_err_o, wbs_rty_o;

  logic [7:0]  dict_mem [0:255];
  logic [31:0] pm_mem   [0:255];
  logic [31:0] pm_word;
  logic        err_en;
  logic [23:0] err_adr;
  logic [1:0]  beat_log [$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  levenshtein_engine #(
    .MASTER_ADDR_WIDTH(24), .SLAVE_ADDR_WIDTH(24), .BITVECTOR_WIDTH(32),
    .DISTANCE_WIDTH(8), .ID_WIDTH(16)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_adr_o(wbm_adr_o),
    .wbm_we_o(wbm_we_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i), .wbm_dat_i(wbm_dat_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o), .wbs_dat_o(wbs_dat_o)
  );

  // Zero-wait memory: dictionary above bit 23, match vectors MSB byte first below.
  always_comb begin
    pm_word   = pm_mem[wbm_adr_o[9:2]];
    wbm_err_i = wbm_cyc_o & err_en & (wbm_adr_o == err_adr);
    wbm_ack_i = wbm_cyc_o & ~wbm_err_i;
    wbm_rty_i = 1'b0;
    if (wbm_adr_o[23]) wbm_dat_i = dict_mem[wbm_adr_o[7:0]];
    else begin
      case (wbm_adr_o[1:0])
        2'd0:    wbm_dat_i = pm_word[31:24];
        2'd1:    wbm_dat_i = pm_word[23:16];
        2'd2:    wbm_dat_i = pm_word[15:8];
        default: wbm_dat_i = pm_word[7:0];
      endcase
    end
  end

  always @(posedge clk)
    if (wbm_cyc_o && wbm_ack_i && !wbm_adr_o[23]) beat_log.push_back(wbm_adr_o[1:0]);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_adr_i = {21'd0, a}; wbs_dat_i = d;
    @(posedge clk); #1;
    check("wbs_ack", 32'(wbs_ack_o), 32'd1);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    $display("wr adr=%0d dat=0x%02h", a, d);
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = {21'd0, a};
    @(posedge clk); #1;
    d = wbs_dat_o;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
  endtask

  task automatic wait_done(output logic [7:0] ctrl);
    ctrl = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      wb_read(ADDR_CTRL, ctrl);
      if (ctrl[2:1] != 2'b00) break;
    end
  endtask

  task automatic load_dict(input logic [127:0] v, input int n);
    for (int i = 0; i < 256; i++) dict_mem[i] = END_OF_DICT;
    for (int i = 0; i < n; i++) dict_mem[i] = v[8*(n-1-i) +: 8];
  endtask

  task automatic query_ab();
    for (int i = 0; i < 256; i++) pm_mem[i] = 32'd0;
    pm_mem[0] = 32'h0000_0001;
    pm_mem[1] = 32'h0000_0002;
  endtask

  // Runs one search with L and reports CTRL/DISTANCE/IDX_LO.
  task automatic run(input string name, input logic [7:0] len,
                     input logic [7:0] exp_dist, input logic [7:0] exp_idx);
    logic [7:0] rd;
    wb_write(ADDR_LENGTH, len);
    wb_write(ADDR_CTRL, 8'h01);
    wait_done(rd);
    check({name, "_ctrl"}, 32'(rd), 32'h02);
    wb_read(ADDR_DISTANCE, rd);
    check({name, "_dist"}, 32'(rd), 32'(exp_dist));
    wb_read(ADDR_IDX_LO, rd);
    check({name, "_idx_lo"}, 32'(rd), 32'(exp_idx));
    $display("run %s done: dist=0x%02h", name, exp_dist);
  endtask

  initial begin
    logic [7:0] rd;
    logic       found;
    rst = 1'b1; err_en = 1'b0; err_adr = 24'd0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_adr_i = '0; wbs_dat_i = '0;
    for (int i = 0; i < 256; i++) begin dict_mem[i] = END_OF_DICT; pm_mem[i] = 32'd0; end
    repeat (3) @(posedge clk);
    #1;
    check("reset_cyc", 32'(wbm_cyc_o), 32'd0);
    check("reset_ack", 32'(wbs_ack_o), 32'd0);
    rst = 1'b0;
    wb_read(ADDR_CTRL, rd);     check("reset_ctrl", 32'(rd), 32'h00);
    wb_read(ADDR_DISTANCE, rd); check("reset_dist", 32'(rd), 32'hFF);
    wb_read(ADDR_IDX_LO, rd);   check("reset_idx", 32'(rd), 32'h00);
    wb_read(ADDR_LENGTH, rd);   check("reset_len", 32'(rd), 32'h00);
    check("we_const", {31'd0, wbm_we_o} | {24'd0, wbm_dat_o}, 32'd0);

    // "ab" against ab, b / b, ab / ab, ab (tie keeps index 0)
    query_ab();
    load_dict(48'h0001FE01FEFF, 6);   run("ab_first", 8'd2, 8'h00, 8'h00);
    load_dict(48'h01FE0001FEFF, 6);   run("ab_second", 8'd2, 8'h00, 8'h01);
    load_dict(56'h0001FE0001FEFF, 7); run("ab_tie", 8'd2, 8'h00, 8'h00);

    // Distances 0, 2, 1 with THRESHOLD=1
    wb_write(ADDR_THRESHOLD, 8'h01);
    load_dict(72'h0001FE0202FE01FEFF, 9); run("thresh", 8'd2, 8'h00, 8'h00);
    wb_read(ADDR_CNT_LO, rd);
`ifdef LEVENSHTEIN_THRESHOLD_EN
    check("cnt_lo", 32'(rd), 32'd2);
    wb_read(ADDR_THRESHOLD, rd); check("thresh_rd", 32'(rd), 32'd1);
`else
    check("cnt_lo", 32'(rd), 32'd0);
    wb_read(ADDR_THRESHOLD, rd); check("thresh_rd", 32'(rd), 32'd0);
`endif
    wb_read(ADDR_CNT_HI, rd); check("cnt_hi", 32'(rd), 32'd0);

    // L=20 query, one substitution at position 7, four MSB-first beats per char
    for (int i = 0; i < 256; i++) begin pm_mem[i] = 32'd0; dict_mem[i] = END_OF_DICT; end
    for (int i = 0; i < 20; i++) begin
      pm_mem[8'h10 + i] = 32'd1 << i;
      dict_mem[i] = (i == 7) ? 8'h50 : 8'(8'h10 + i);
    end
    dict_mem[20] = END_OF_WORD;
    beat_log.delete();
    run("len20", 8'd20, 8'h01, 8'h00);
    check("len20_beats", 32'(beat_log.size()), 32'd80);
    for (int i = 0; i < 4; i++) check("len20_beat_order", 32'(beat_log[i]), 32'(i));

    // Error on beat 1 of character 0's vector
    query_ab();
    load_dict(32'h0001FEFF, 4);
    err_adr = 24'h000001; err_en = 1'b1; found = 1'b0;
    wb_write(ADDR_LENGTH, 8'd2);
    wb_write(ADDR_CTRL, 8'h01);
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      if (wbm_cyc_o && wbm_adr_o == err_adr) found = 1'b1;
    end
    check("err_beat_seen", 32'(found), 32'd1);
    @(posedge clk); #1;
    check("err_cyc_low", 32'(wbm_cyc_o), 32'd0);
    err_en = 1'b0;
    wb_read(ADDR_CTRL, rd);     check("err_ctrl", 32'(rd), 32'h04);
    wb_read(ADDR_DISTANCE, rd); check("err_dist", 32'(rd), 32'hFF);
    $display("run err_beat done");

    // Illegal lengths
    wb_write(ADDR_LENGTH, 8'd0);  wb_write(ADDR_CTRL, 8'h01);
    wb_read(ADDR_CTRL, rd); check("len0_ctrl", 32'(rd), 32'h04);
    wb_write(ADDR_LENGTH, 8'd33); wb_write(ADDR_CTRL, 8'h01);
    wb_read(ADDR_CTRL, rd); check("len33_ctrl", 32'(rd), 32'h04);

    // Mid-run restart: five "b" words then "ab" -> best index 5 only if idx restarts
    for (int i = 0; i < 256; i++) dict_mem[i] = END_OF_DICT;
    for (int i = 0; i < 5; i++) begin dict_mem[2*i] = 8'h01; dict_mem[2*i+1] = END_OF_WORD; end
    dict_mem[10] = 8'h00; dict_mem[11] = 8'h01; dict_mem[12] = END_OF_WORD;
    wb_write(ADDR_LENGTH, 8'd2);
    wb_write(ADDR_CTRL, 8'h01);
    repeat (45) @(posedge clk);
    wb_write(ADDR_CTRL, 8'h01);
    check("restart_cyc_low", 32'(wbm_cyc_o), 32'd0);
    @(posedge clk); #1;
    check("restart_cyc_rise", 32'(wbm_cyc_o), 32'd1);
    check("restart_adr", 32'(wbm_adr_o), 32'h800000);
    wait_done(rd);
    check("restart_ctrl", 32'(rd), 32'h02);
    wb_read(ADDR_IDX_LO, rd);   check("restart_idx", 32'(rd), 32'd5);
    wb_read(ADDR_DISTANCE, rd); check("restart_dist", 32'(rd), 32'd0);
    $display("run restart done");

    // Asynchronous reset while a beat is in flight
    wb_write(ADDR_CTRL, 8'h01);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk); #1;
      if (wbm_cyc_o) found = 1'b1;
    end
    check("areset_cyc_seen", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1 check("areset_cyc_low", 32'(wbm_cyc_o), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    wb_read(ADDR_CTRL, rd);     check("areset_ctrl", 32'(rd), 32'h00);
    wb_read(ADDR_DISTANCE, rd); check("areset_dist", 32'(rd), 32'hFF);
    wb_read(ADDR_LENGTH, rd);   check("areset_len", 32'(rd), 32'h00);
    $display("run async_reset done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
